// File: rtl/pa_dcache_dirty_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pa_dcache_dirty_pkg                                                        |
// | Shared encodings and constants for the D-cache dirty-bit array controller. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pa_dcache_dirty_pkg;

  localparam int WAYS       = 4;
  localparam int IDX_PORT_W = 10;

  // The SRAM write enables are active low.
  localparam logic [WAYS-1:0] WEN_NONE = 4'b1111;
  localparam logic [WAYS-1:0] WEN_ALL  = 4'b0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_RD   = 3'd1,
    S_CHK  = 3'd2,
    S_VIC  = 3'd3,
    S_NXT  = 3'd4,
    S_DONE = 3'd5
  } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/pa_dcache_dirty_prio4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pa_dcache_dirty_prio4                                                      |
// | Lowest-set-bit one-hot picker used to select the next dirty victim way.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pa_dcache_dirty_prio4
  import pa_dcache_dirty_pkg::*;
(
  input  logic [WAYS-1:0] req,
  output logic [WAYS-1:0] gnt
);

  // Two's-complement trick: isolates the lowest set bit, zero when req is zero.
  assign gnt = req & (~req + WAYS'(1));

endmodule
`default_nettype wire

// File: rtl/pa_dcache_dirty_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pa_dcache_dirty_ctrl                                                       |
// | Dirty-bit SRAM port arbiter plus clean-all / invalidate-all sweep FSM.     |
// | Optional macro PA_DCACHE_SWEEP_ABORT_EN adds the sweep_abort input.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pa_dcache_dirty_ctrl
  import pa_dcache_dirty_pkg::*;
#(
  parameter int INDEX_W = 7
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  rf_req,
  input  logic [IDX_PORT_W-1:0] rf_idx,
  input  logic [WAYS-1:0]       rf_way,
  input  logic                  rf_dirty,
  output logic                  rf_gnt,
  input  logic                  st_req,
  input  logic [IDX_PORT_W-1:0] st_idx,
  input  logic [WAYS-1:0]       st_way,
  output logic                  st_gnt,
  input  logic                  rd_req,
  input  logic [IDX_PORT_W-1:0] rd_idx,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [WAYS-1:0]       rd_dirty,
  input  logic                  sweep_start,
  input  logic                  sweep_inv,
`ifdef PA_DCACHE_SWEEP_ABORT_EN
  input  logic                  sweep_abort,
`endif
  output logic                  sweep_busy,
  output logic                  sweep_done,
  output logic                  vic_vld,
  output logic [IDX_PORT_W-1:0] vic_idx,
  output logic [WAYS-1:0]       vic_way,
  input  logic                  vic_rdy,
  output logic                  dirty_clk_en,
  output logic                  dirty_cen,
  output logic                  dirty_gwen,
  output logic [WAYS-1:0]       dirty_wen,
  output logic [WAYS-1:0]       dirty_din,
  output logic [IDX_PORT_W-1:0] dirty_idx,
  input  logic [WAYS-1:0]       dirty_q
);

  sweep_state_t       r_state;
  logic [INDEX_W-1:0] r_cnt;
  logic               r_inv;
  logic               r_abort_pend;
  logic [WAYS-1:0]    r_mask;
  logic               r_rd_vld;
  logic [WAYS-1:0]    r_rd_hold;

  logic               w_idle;
  logic               w_arb;
  logic               w_abort;
  logic [WAYS-1:0]    w_vic_way;
  logic [WAYS-1:0]    w_mask_left;
  logic [INDEX_W-1:0] w_sram_idx;
  logic               w_unused_idx;

`ifdef PA_DCACHE_SWEEP_ABORT_EN
  assign w_abort = sweep_abort;
`else
  assign w_abort = 1'b0;
`endif

  pa_dcache_dirty_prio4 u_prio (
    .req (r_mask),
    .gnt (w_vic_way)
  );

  // Gating on cpurst keeps every grant and SRAM strobe inactive for the whole reset.
  assign w_idle = (r_state == IDLE) && !cpurst;
  assign w_arb  = w_idle && !sweep_start;
  assign rf_gnt = w_arb && rf_req;
  assign st_gnt = w_arb && !rf_req && st_req;
  assign rd_gnt = w_arb && !rf_req && !st_req && rd_req;

  assign w_mask_left = r_mask & ~w_vic_way;

  assign sweep_busy = (r_state != IDLE);
  assign sweep_done = (r_state == S_DONE);
  assign vic_vld    = (r_state == S_VIC);
  assign vic_way    = vic_vld ? w_vic_way : '0;

  always_comb begin
    vic_idx = '0;
    if (vic_vld) vic_idx[INDEX_W-1:0] = r_cnt;
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_inv        <= 1'b0;
      r_abort_pend <= 1'b0;
      r_mask       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sweep_start) begin
            r_cnt        <= '0;
            r_inv        <= sweep_inv;
            r_abort_pend <= 1'b0;
            r_state      <= S_RD;
          end
        end
        S_RD: r_state <= S_CHK;
        S_CHK: begin
          if (r_inv) begin
            r_state <= S_NXT;
          end else begin
            r_mask <= dirty_q;
            if (dirty_q != '0) r_state <= S_VIC;
            else               r_state <= w_abort ? S_DONE : S_NXT;
          end
        end
        S_VIC: begin
          // An abort here only takes effect once this index has no victims left.
          if (w_abort) r_abort_pend <= 1'b1;
          if (vic_rdy) begin
            r_mask <= w_mask_left;
            if (w_mask_left == '0) r_state <= S_NXT;
          end
        end
        S_NXT: begin
          if (w_abort || r_abort_pend || (r_cnt == {INDEX_W{1'b1}})) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_RD;
          end
        end
        S_DONE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_rd_vld  <= 1'b0;
      r_rd_hold <= '0;
    end else begin
      r_rd_vld <= rd_gnt;
      if (r_rd_vld) r_rd_hold <= dirty_q;
    end
  end

  // SRAM Q is live only in the cycle after the read; the hold register covers later cycles.
  assign rd_vld   = r_rd_vld;
  assign rd_dirty = r_rd_vld ? dirty_q : r_rd_hold;

  always_comb begin
    dirty_cen  = 1'b1;
    dirty_gwen = 1'b1;
    dirty_wen  = WEN_NONE;
    dirty_din  = '0;
    w_sram_idx = '0;
    if (rf_gnt) begin
      dirty_cen  = 1'b0;
      dirty_gwen = 1'b0;
      dirty_wen  = ~rf_way;
      dirty_din  = {WAYS{rf_dirty}};
      w_sram_idx = rf_idx[INDEX_W-1:0];
    end else if (st_gnt) begin
      dirty_cen  = 1'b0;
      dirty_gwen = 1'b0;
      dirty_wen  = ~st_way;
      dirty_din  = {WAYS{1'b1}};
      w_sram_idx = st_idx[INDEX_W-1:0];
    end else if (rd_gnt) begin
      dirty_cen  = 1'b0;
      w_sram_idx = rd_idx[INDEX_W-1:0];
    end else if (!cpurst) begin
      case (r_state)
        S_RD: begin
          dirty_cen  = 1'b0;
          w_sram_idx = r_cnt;
        end
        S_CHK: begin
          if (r_inv) begin
            dirty_cen  = 1'b0;
            dirty_gwen = 1'b0;
            dirty_wen  = WEN_ALL;
            w_sram_idx = r_cnt;
          end
        end
        S_VIC: begin
          if (vic_rdy) begin
            dirty_cen  = 1'b0;
            dirty_gwen = 1'b0;
            dirty_wen  = ~w_vic_way;
            w_sram_idx = r_cnt;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dirty_idx = '0;
    dirty_idx[INDEX_W-1:0] = w_sram_idx;
  end

  assign dirty_clk_en = !dirty_cen || r_rd_vld;

  // Index bits above INDEX_W-1 are intentionally ignored.
  assign w_unused_idx = ^{rf_idx, st_idx, rd_idx};

endmodule
`default_nettype wire

// File: tb/tb_pa_dcache_dirty_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pa_dcache_dirty_ctrl                                                    |
// | Self-checking bench: vector table, read-data scoreboard, sweep sequences.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pa_dcache_dirty_ctrl;

  logic       clk = 1'b0;
  logic       cpurst;
  logic       rf_req, st_req, rd_req, rf_dirty;
  logic [9:0] rf_idx, st_idx, rd_idx;
  logic [3:0] rf_way, st_way;
  logic       rf_gnt, st_gnt, rd_gnt, rd_vld;
  logic [3:0] rd_dirty;
  logic       sweep_start, sweep_inv, sweep_abort;
  logic       sweep_busy, sweep_done, vic_vld, vic_rdy;
  logic [9:0] vic_idx;
  logic [3:0] vic_way;
  logic       dirty_clk_en, dirty_cen, dirty_gwen;
  logic [3:0] dirty_wen, dirty_din, dirty_q;
  logic [9:0] dirty_idx;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mem [0:1023];

  always #5 clk = ~clk;

  pa_dcache_dirty_ctrl #(.INDEX_W(7)) dut (
    .forever_cpuclk(clk), .cpurst(cpurst),
    .rf_req(rf_req), .rf_idx(rf_idx), .rf_way(rf_way), .rf_dirty(rf_dirty), .rf_gnt(rf_gnt),
    .st_req(st_req), .st_idx(st_idx), .st_way(st_way), .st_gnt(st_gnt),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_dirty(rd_dirty),
    .sweep_start(sweep_start), .sweep_inv(sweep_inv),
`ifdef PA_DCACHE_SWEEP_ABORT_EN
    .sweep_abort(sweep_abort),
`endif
    .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .vic_vld(vic_vld), .vic_idx(vic_idx), .vic_way(vic_way), .vic_rdy(vic_rdy),
    .dirty_clk_en(dirty_clk_en), .dirty_cen(dirty_cen), .dirty_gwen(dirty_gwen),
    .dirty_wen(dirty_wen), .dirty_din(dirty_din), .dirty_idx(dirty_idx), .dirty_q(dirty_q)
  );

  // Behavioural single-port SRAM with active-low controls and bit write mask.
  always @(posedge clk) begin
    if (!dirty_cen) begin
      if (!dirty_gwen) begin
        for (int b = 0; b < 4; b++)
          if (!dirty_wen[b]) mem[dirty_idx][b] <= dirty_din[b];
      end else begin
        dirty_q <= mem[dirty_idx];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every granted read pushes its expected data; rd_vld pops it.
  always @(negedge clk) begin : mon
    logic [3:0] e;
    if (!cpurst && rd_vld) begin
      if (exp_q.size() == 0) begin
        check("rd_vld_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rd_dirty", {28'd0, rd_dirty}, {28'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string t);
    check({t, "_gnts"}, {29'd0, rf_gnt, st_gnt, rd_gnt}, 32'd0);
    check({t, "_rd_vld"}, {31'd0, rd_vld}, 32'd0);
    check({t, "_rd_dirty"}, {28'd0, rd_dirty}, 32'd0);
    check({t, "_busy_done"}, {30'd0, sweep_busy, sweep_done}, 32'd0);
    check({t, "_vic"}, {17'd0, vic_vld, vic_idx, vic_way}, 32'd0);
    check({t, "_cen_gwen"}, {30'd0, dirty_cen, dirty_gwen}, 32'd3);
    check({t, "_wen"}, {28'd0, dirty_wen}, 32'hf);
    check({t, "_din_idx"}, {18'd0, dirty_din, dirty_idx}, 32'd0);
    check({t, "_clk_en"}, {31'd0, dirty_clk_en}, 32'd0);
  endtask

  task automatic store(input logic [9:0] idx, input logic [3:0] way);
    st_req = 1'b1; st_idx = idx; st_way = way;
    @(negedge clk);
    check("store_gnt", {31'd0, st_gnt}, 32'd1);
    step();
    st_req = 1'b0;
  endtask

  task automatic read(input logic [9:0] idx, input logic [3:0] e);
    rd_req = 1'b1; rd_idx = idx;
    @(negedge clk);
    check("read_gnt", {31'd0, rd_gnt}, 32'd1);
    if (rd_gnt) exp_q.push_back(e);
    step();
    rd_req = 1'b0;
    step();
    step();
  endtask

  typedef struct {
    logic       rf, st, rd;
    logic [9:0] idx;
    logic [3:0] way;
    logic       dirty;
    logic [2:0] gnt;
    logic       cen, gwen;
    logic [3:0] wen, din;
    logic [9:0] eidx;
    logic [3:0] rdat;
  } vec_t;

  vec_t vt[12];

  initial begin
    int ncyc, nbusy, nwr, nvic, vcyc, wt;
    logic done, vic_seen, gnt_seen, rd11;
    logic [3:0] ew;

    vt[0]  = '{1'b1, 1'b0, 1'b0, 10'h005, 4'b0100, 1'b1, 3'b100, 1'b0, 1'b0, 4'b1011, 4'b1111, 10'd5, 4'b0000};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 10'h005, 4'b0000, 1'b0, 3'b001, 1'b0, 1'b1, 4'b1111, 4'b0000, 10'd5, 4'b0100};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 10'h007, 4'b0001, 1'b0, 3'b100, 1'b0, 1'b0, 4'b1110, 4'b0000, 10'd7, 4'b0000};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 10'h007, 4'b0001, 1'b0, 3'b010, 1'b0, 1'b0, 4'b1110, 4'b1111, 10'd7, 4'b0000};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 10'h007, 4'b0001, 1'b0, 3'b001, 1'b0, 1'b1, 4'b1111, 4'b0000, 10'd7, 4'b0001};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 10'h007, 4'b0001, 1'b1, 3'b000, 1'b1, 1'b1, 4'b1111, 4'b0000, 10'd0, 4'b0000};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 10'h003, 4'b0010, 1'b0, 3'b010, 1'b0, 1'b0, 4'b1101, 4'b1111, 10'd3, 4'b0000};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 10'h003, 4'b1000, 1'b0, 3'b010, 1'b0, 1'b0, 4'b0111, 4'b1111, 10'd3, 4'b0000};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 10'h003, 4'b0000, 1'b0, 3'b001, 1'b0, 1'b1, 4'b1111, 4'b0000, 10'd3, 4'b1010};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 10'h389, 4'b0001, 1'b1, 3'b100, 1'b0, 1'b0, 4'b1110, 4'b1111, 10'd9, 4'b0000};
    vt[10] = '{1'b1, 1'b0, 1'b0, 10'h009, 4'b0010, 1'b0, 3'b100, 1'b0, 1'b0, 4'b1101, 4'b0000, 10'd9, 4'b0000};
    vt[11] = '{1'b0, 1'b0, 1'b1, 10'h209, 4'b0000, 1'b0, 3'b001, 1'b0, 1'b1, 4'b1111, 4'b0000, 10'd9, 4'b0001};

    for (int i = 0; i < 1024; i++) mem[i] = 4'b0000;
    dirty_q = 4'b0000;
    cpurst = 1'b1;
    rf_req = 0; st_req = 0; rd_req = 0; rf_dirty = 0;
    rf_idx = 0; st_idx = 0; rd_idx = 0; rf_way = 0; st_way = 0;
    sweep_start = 0; sweep_inv = 0; sweep_abort = 0; vic_rdy = 0;
    repeat (2) step();
    @(negedge clk);
    check_reset_outs("reset");
    step();
    cpurst = 1'b0;

    // Arbitration and SRAM control vectors.
    for (int i = 0; i < 12; i++) begin
      rf_req = vt[i].rf; st_req = vt[i].st; rd_req = vt[i].rd;
      rf_idx = vt[i].idx; st_idx = vt[i].idx; rd_idx = vt[i].idx;
      rf_way = vt[i].way; st_way = vt[i].way; rf_dirty = vt[i].dirty;
      @(negedge clk);
      check($sformatf("v%0d_gnt", i), {29'd0, rf_gnt, st_gnt, rd_gnt}, {29'd0, vt[i].gnt});
      check($sformatf("v%0d_cen_gwen", i), {30'd0, dirty_cen, dirty_gwen}, {30'd0, vt[i].cen, vt[i].gwen});
      check($sformatf("v%0d_wen_din", i), {24'd0, dirty_wen, dirty_din}, {24'd0, vt[i].wen, vt[i].din});
      check($sformatf("v%0d_idx", i), {22'd0, dirty_idx}, {22'd0, vt[i].eidx});
      check($sformatf("v%0d_clk_en", i), {31'd0, dirty_clk_en},
            {31'd0, (vt[i].gnt != 3'b000) || (i > 0 && vt[i-1].gnt == 3'b001)});
      if (rd_gnt) exp_q.push_back(vt[i].rdat);
      step();
    end
    rf_req = 0; st_req = 0; rd_req = 0;
    step();
    @(negedge clk);
    check("rd_hold_vld", {31'd0, rd_vld}, 32'd0);
    check("rd_hold_data", {28'd0, rd_dirty}, 32'h1);
    step();

    // Invalidate sweep with a competing read held throughout.
    rd_req = 1'b1; rd_idx = 10'd0;
    sweep_start = 1'b1; sweep_inv = 1'b1;
    @(negedge clk);
    check("inv_start_gnt", {31'd0, rd_gnt}, 32'd0);
    ncyc = 1; nbusy = 0; nwr = 0; done = 0; vic_seen = 0; gnt_seen = 0;
    step();
    sweep_start = 1'b0; sweep_inv = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      ncyc++;
      if (sweep_busy) nbusy++;
      if (!dirty_cen && !dirty_gwen && dirty_wen == 4'b0000 && dirty_din == 4'b0000) nwr++;
      if (vic_vld) vic_seen = 1;
      if (rf_gnt || st_gnt || rd_gnt) gnt_seen = 1;
      if (sweep_done) done = 1;
      step();
    end
    rd_req = 1'b0;
    check("inv_done", {31'd0, done}, 32'd1);
    check("inv_cycles", ncyc, 1 + 3 * 128 + 1);
    check("inv_busy_cycles", nbusy, 3 * 128 + 1);
    check("inv_writes", nwr, 128);
    check("inv_no_vic", {31'd0, vic_seen}, 32'd0);
    check("inv_no_gnt", {31'd0, gnt_seen}, 32'd0);
    step();
    read(10'd5, 4'b0000);

    // Clean sweep: idx3 = 1010, write-back engine answers after two wait cycles.
    store(10'd3, 4'b0010);
    store(10'd3, 4'b1000);
    sweep_start = 1'b1; sweep_inv = 1'b0;
    step();
    sweep_start = 1'b0;
    nvic = 0; vcyc = 0; wt = 0; done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      vic_rdy = vic_vld && (wt == 2);
      @(negedge clk);
      if (vic_vld) begin
        vcyc++;
        ew = (nvic == 0) ? 4'b0010 : 4'b1000;
        check("clean_vic_way", {28'd0, vic_way}, {28'd0, ew});
        check("clean_vic_idx", {22'd0, vic_idx}, 32'd3);
        if (vic_rdy) begin
          check("clean_wr_ctl", {30'd0, dirty_cen, dirty_gwen}, 32'd0);
          check("clean_wr_wen_din", {24'd0, dirty_wen, dirty_din}, {24'd0, ~ew, 4'b0000});
          check("clean_wr_idx", {22'd0, dirty_idx}, 32'd3);
          nvic++;
          wt = 0;
        end else begin
          wt++;
        end
      end
      if (sweep_done) done = 1;
      step();
    end
    vic_rdy = 1'b0;
    check("clean_done", {31'd0, done}, 32'd1);
    check("clean_victims", nvic, 2);
    check("clean_vic_cycles", vcyc, 6);
    read(10'd3, 4'b0000);

    // Reset while a victim is being offered.
    store(10'd20, 4'b0001);
    store(10'd20, 4'b0010);
    sweep_start = 1'b1; sweep_inv = 1'b0;
    step();
    sweep_start = 1'b0;
    done = 0;
    for (int c = 0; c < 2000 && !vic_vld; c++) step();
    check("rst_reach_vic", {22'd0, vic_vld, vic_idx}, {22'd0, 1'b1, 10'd20});
    cpurst = 1'b1; rd_req = 1'b1; rd_idx = 10'd20;
    #1;
    check_reset_outs("midrst");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (sweep_done || sweep_busy || rd_gnt) done = 1;
    end
    check("midrst_quiet", {31'd0, done}, 32'd0);
    step();
    cpurst = 1'b0;
    read(10'd20, 4'b0011);

`ifdef PA_DCACHE_SWEEP_ABORT_EN
    // Abort while idx10 still has two victims; idx11 must never be read.
    store(10'd10, 4'b0001);
    store(10'd10, 4'b0010);
    store(10'd11, 4'b0001);
    sweep_start = 1'b1; sweep_inv = 1'b0;
    step();
    sweep_start = 1'b0;
    for (int c = 0; c < 2000 && !vic_vld; c++) step();
    check("abort_vic_idx", {22'd0, vic_idx}, 32'd10);
    sweep_abort = 1'b1;
    step();
    sweep_abort = 1'b0;
    nvic = 0; done = 0; rd11 = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      vic_rdy = vic_vld;
      @(negedge clk);
      if (vic_vld && vic_rdy) nvic++;
      if (!dirty_cen && dirty_gwen && dirty_idx == 10'd11) rd11 = 1;
      if (sweep_done) done = 1;
      step();
    end
    vic_rdy = 1'b0;
    check("abort_done", {31'd0, done}, 32'd1);
    check("abort_victims", nvic, 2);
    check("abort_idx11_untouched", {31'd0, rd11}, 32'd0);
    read(10'd10, 4'b0000);
    read(10'd11, 4'b0001);
`endif

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
